pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch sequencer.
// Holds the architectural PC, fetches one word at a time from instruction
// memory, presents it to decode and waits for the resolved next PC before
// starting the next fetch. A halt request parks the unit until reset.

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   input  logic        npc_valid,
   input  logic        halt,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        halted,
   output logic [15:0] retired_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      ISSUE    = 3'd2,
      WAIT_NPC = 3'd3,
      HALTED   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instrPc_q, instrPc_d;
   logic [15:0] retiredCnt_q, retiredCnt_d;

   // Next-state logic: each input is only acted on in the one state that owns
   // it, so stray acks, ready pulses and npc_valid pulses fall through to hold.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      instrPc_d    = instrPc_q;
      retiredCnt_d = retiredCnt_q;
      case (state_q)
         IDLE: begin
            state_d = halt ? HALTED : FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d   = imem_rdata;
               instrPc_d = pc_q;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               state_d = WAIT_NPC;
            end
         end
         WAIT_NPC: begin
            if (npc_valid) begin
               pc_d = npc;
               if (retiredCnt_q != 16'hFFFF) begin
                  retiredCnt_d = retiredCnt_q + 16'd1;
               end
               state_d = halt ? HALTED : FETCH;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset also abandons
   // any outstanding fetch because FETCH is the only state that listens to ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= 32'h0;
         instrPc_q    <= 32'h0;
         retiredCnt_q <= 16'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         instrPc_q    <= instrPc_d;
         retiredCnt_q <= retiredCnt_d;
      end
   end

   assign pc          = pc_q;
   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instrPc_q;
   assign instr_valid = (state_q == ISSUE);
   assign halted      = (state_q == HALTED);
   assign retired_cnt = retiredCnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit. Fetched words are
// pushed when the ack is driven and popped when decode takes them.

module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] npc;
   logic        npc_valid;
   logic        halt;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        halted;
   logic [15:0] retired_cnt;

   int          assertCount = 0;
   int          failCount   = 0;
   logic [63:0] expQ[$];
   logic [15:0] expCnt;
   logic [31:0] expPc;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .npc         (npc),
      .npc_valid   (npc_valid),
      .halt        (halt),
      .pc          (pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .halted      (halted),
      .retired_cnt (retired_cnt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rstN, input logic ack, input logic [31:0] rdata,
                                input logic ready, input logic nv, input logic [31:0] nextPc,
                                input logic hlt);
      rst_n       = rstN;
      imem_ack    = ack;
      imem_rdata  = rdata;
      instr_ready = ready;
      npc_valid   = nv;
      npc         = nextPc;
      halt        = hlt;
   endtask

   // Wait (bounded) for a request, check its address, ack it with data.
   task automatic doFetch(input logic [31:0] data);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("fetchReq", {31'h0, imem_req}, 32'h1);
      checkOutput("fetchAddr", imem_addr, expPc);
      applyStimulus(1'b1, 1'b1, data, 1'b0, 1'b0, 32'h0, 1'b0);
      expQ.push_back({data, expPc});
      tick();
      applyStimulus(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("validAfterAck", {31'h0, instr_valid}, 32'h1);
      checkOutput("reqAfterAck", {31'h0, imem_req}, 32'h0);
   endtask

   // Decode accepts the word; compare it against the scoreboard head.
   task automatic doHandshake();
      logic [63:0] e;
      instr_ready = 1'b1;
      if (expQ.size() == 0) begin
         checkOutput("sbEmpty", 32'h1, 32'h0);
      end else begin
         e = expQ.pop_front();
         checkOutput("sbInstr", instr, e[63:32]);
         checkOutput("sbInstrPc", instr_pc, e[31:0]);
      end
      checkOutput("hsValid", {31'h0, instr_valid}, 32'h1);
      tick();
      instr_ready = 1'b0;
      checkOutput("validDrop", {31'h0, instr_valid}, 32'h0);
   endtask

   task automatic doCommit(input logic [31:0] nextPc, input logic hlt);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, nextPc, hlt);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      expPc  = nextPc;
      expCnt = (expCnt == 16'hFFFF) ? expCnt : expCnt + 16'd1;
      checkOutput("commitPc", pc, expPc);
      checkOutput("commitCnt", {16'h0, retired_cnt}, {16'h0, expCnt});
      checkOutput("commitHalted", {31'h0, halted}, {31'h0, hlt});
      checkOutput("commitReq", {31'h0, imem_req}, {31'h0, ~hlt});
   endtask

   task automatic doReset(input int cycles);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < cycles; i++) tick();
      expPc  = 32'h0;
      expCnt = 16'h0;
      expQ.delete();
   endtask

   // Main sequence.
   initial begin
      int reqSeen;
      expPc  = 32'h0;
      expCnt = 16'h0;
      doReset(3);
      checkOutput("rstPc", pc, 32'h0);
      checkOutput("rstInstr", instr, 32'h0);
      checkOutput("rstInstrPc", instr_pc, 32'h0);
      checkOutput("rstValid", {31'h0, instr_valid}, 32'h0);
      checkOutput("rstReq", {31'h0, imem_req}, 32'h0);
      checkOutput("rstHalted", {31'h0, halted}, 32'h0);
      checkOutput("rstCnt", {16'h0, retired_cnt}, 32'h0);

      // Release: one IDLE cycle, then the fetch request.
      rst_n = 1'b1;
      checkOutput("idleNoReq", {31'h0, imem_req}, 32'h0);
      tick();
      checkOutput("firstReq", {31'h0, imem_req}, 32'h1);
      doFetch(32'h1234_5678);
      checkOutput("firstInstr", instr, 32'h1234_5678);
      checkOutput("firstInstrPc", instr_pc, 32'h0);

      // Decode stalls 3 cycles; stray npc_valid in ISSUE is ignored.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'hBAD0_0000 + i, 1'b0, (i == 1), 32'h0000_0BAD, 1'b0);
         tick();
         checkOutput("stallValid", {31'h0, instr_valid}, 32'h1);
         checkOutput("stallInstr", instr, 32'h1234_5678);
         checkOutput("stallPc", pc, 32'h0);
         checkOutput("stallCnt", {16'h0, retired_cnt}, 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      doHandshake();
      doCommit(32'h10, 1'b0);

      // Stray npc_valid during FETCH, then ack arriving with ready high.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0);
      tick();
      checkOutput("fetchNpcPc", pc, 32'h10);
      checkOutput("fetchNpcCnt", {16'h0, retired_cnt}, 32'h1);
      applyStimulus(1'b1, 1'b1, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'h0, 1'b0);
      expQ.push_back({32'hA5A5_5A5A, expPc});
      tick();
      checkOutput("ackReadyIgnored", {31'h0, instr_valid}, 32'h1);

      // halt raised in ISSUE and held until the commit.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("haltInIssue", {31'h0, halted}, 32'h0);
      doHandshake();
      halt = 1'b1;
      tick();
      checkOutput("waitNoReq", {31'h0, imem_req}, 32'h0);
      doCommit(32'h20, 1'b1);
      reqSeen = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b1, $urandom, 1'b0);
         tick();
         if (imem_req !== 1'b0 || pc !== 32'h20 || halted !== 1'b1) reqSeen++;
      end
      checkOutput("haltedQuiet", reqSeen, 32'h0);
      checkOutput("haltedCnt", {16'h0, retired_cnt}, 32'h2);
      doReset(1);
      checkOutput("haltRstPc", pc, 32'h0);
      checkOutput("haltRstHalted", {31'h0, halted}, 32'h0);

      // Move pc away from RESET_PC, then reset mid-fetch with a late ack.
      rst_n = 1'b1;
      tick();
      doFetch(32'h0000_1111);
      doHandshake();
      doCommit(32'h40, 1'b0);
      checkOutput("preRstAddr", imem_addr, 32'h40);
      rst_n = 1'b0;
      tick();
      checkOutput("midRstReq", {31'h0, imem_req}, 32'h0);
      checkOutput("midRstPc", pc, 32'h0);
      expPc = 32'h0; expCnt = 16'h0;
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("lateAckValid", {31'h0, instr_valid}, 32'h0);
      checkOutput("lateAckAddr", imem_addr, 32'h0);
      tick();
      checkOutput("lateAckValid2", {31'h0, instr_valid}, 32'h0);
      checkOutput("lateAckInstr", instr, 32'h0);

      // Saturating counter and full-range npc values.
      doFetch(32'h00C0_FFEE);
      doHandshake();
      force dut.retiredCnt_q = 16'hFFFF;
      tick();
      release dut.retiredCnt_q;
      expCnt = 16'hFFFF;
      checkOutput("forcedCnt", {16'h0, retired_cnt}, 32'h0000_FFFF);
      doCommit(32'hFFFF_FFFF, 1'b0);
      checkOutput("maxAddr", imem_addr, 32'hFFFF_FFFF);
      doFetch(32'h7777_0000);
      doHandshake();
      doCommit(32'h0, 1'b0);
      checkOutput("wrapAddr", imem_addr, 32'h0);

      // halt during the IDLE cycle goes straight to HALTED.
      doReset(1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      halt = 1'b0;
      checkOutput("idleHalt", {31'h0, halted}, 32'h1);
      checkOutput("idleHaltReq", {31'h0, imem_req}, 32'h0);

      checkOutput("sbDrained", expQ.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
